// File: rtl/mem_pkg.sv
// Shared definitions for the memory port arbiter: access sizes, FSM states and lane helpers.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam int unsigned WORD_BYTES = 4;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StData,
    StResp
  } state_e;

  function automatic int unsigned bytes_per_word(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Extracts the addressed lanes of a memory read word and sign/zero-extends them.
module mem_load_align
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic [DATA_WIDTH-1:0]           i_rdata,
  input  logic [$clog2(DATA_WIDTH/8)-1:0] i_offset,
  input  logic [1:0]                      i_size,
  input  logic                            i_unsigned,
  output logic [DATA_WIDTH-1:0]           o_data
);

  localparam int BYTES = int'(bytes_per_word(DATA_WIDTH));

  int                    w_nbytes;
  int                    w_shift;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_raw;
  logic [DATA_WIDTH-1:0] w_top;

  // Big-endian lanes count down from the MSB, so the field ends 8*(k+n) bits below the top.
  always_comb begin
    w_nbytes = 1 << i_size;
    if (w_nbytes > BYTES) w_nbytes = BYTES;
    w_shift  = BIG_ENDIAN ? int'(DATA_WIDTH) - 8 * (int'(i_offset) + w_nbytes)
                          : 8 * int'(i_offset);
    w_mask   = ~({DATA_WIDTH{1'b1}} << (8 * w_nbytes));
    w_raw    = (i_rdata >> w_shift) & w_mask;
    w_top    = w_raw >> (8 * w_nbytes - 1);
    o_data   = (!i_unsigned && w_top[0]) ? (w_raw | ~w_mask) : w_raw;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter of an instruction-fetch port and a data port onto one memory port,
// with lane alignment, byte enables, load extension and misalignment faults.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter bit          BIG_ENDIAN = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_req,
  input  logic [ADDR_WIDTH-1:0]   if_addr,
  output logic                    if_ready,
  output logic [31:0]             if_rdata,
  input  logic                    d_req,
  input  logic                    d_we,
  input  logic [1:0]              d_size,
  input  logic                    d_unsigned,
  input  logic [ADDR_WIDTH-1:0]   d_addr,
  input  logic [DATA_WIDTH-1:0]   d_wdata,
  output logic                    d_ready,
  output logic [DATA_WIDTH-1:0]   d_rdata,
  output logic                    d_fault,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH/8-1:0] mem_be,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic                    mem_ack,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int BYTES     = int'(bytes_per_word(DATA_WIDTH));
  localparam int LANE_BITS = $clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] LANE_MASK = ADDR_WIDTH'(BYTES - 1);

  state_e r_state;
  logic   r_last_data;
  logic   r_word_sel;

  logic                  w_pick_data;
  logic                  w_fault;
  int                    w_nbytes;
  int                    w_k;
  int                    w_shift;
  int                    w_be_shift;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_st_data;
  logic [BYTES-1:0]      w_st_be;
  logic [DATA_WIDTH-1:0] w_load;
  logic [DATA_WIDTH-1:0] w_fetch_shifted;

  // r_last_data resets to 0 ("fetch"), so data wins the first tie.
  assign w_pick_data = d_req && (!if_req || !r_last_data);

  always_comb begin
    unique case (d_size)
      SZ_BYTE: w_fault = 1'b0;
      SZ_HALF: w_fault = d_addr[0];
      SZ_WORD: w_fault = |d_addr[1:0];
      default: w_fault = (DATA_WIDTH < 64) || (|d_addr[2:0]);
    endcase
  end

  always_comb begin
    w_nbytes = 1 << d_size;
    if (w_nbytes > BYTES) w_nbytes = BYTES;
    w_k        = int'(d_addr[LANE_BITS-1:0]);
    w_shift    = BIG_ENDIAN ? int'(DATA_WIDTH) - 8 * (w_k + w_nbytes) : 8 * w_k;
    w_be_shift = BIG_ENDIAN ? BYTES - w_k - w_nbytes : w_k;
    w_mask     = ~({DATA_WIDTH{1'b1}} << (8 * w_nbytes));
    w_st_data  = (d_wdata & w_mask) << w_shift;
    w_st_be    = (~({BYTES{1'b1}} << w_nbytes)) << w_be_shift;
  end

  mem_load_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_load_align (
    .i_rdata    (mem_rdata),
    .i_offset   (d_addr[LANE_BITS-1:0]),
    .i_size     (d_size),
    .i_unsigned (d_unsigned),
    .o_data     (w_load)
  );

  assign w_fetch_shifted = mem_rdata >> {r_word_sel, 5'd0};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StIdle;
      r_last_data <= 1'b0;
      r_word_sel  <= 1'b0;
      if_ready    <= 1'b0;
      if_rdata    <= '0;
      d_ready     <= 1'b0;
      d_rdata     <= '0;
      d_fault     <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_be      <= '0;
      mem_wdata   <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_pick_data) begin
            r_last_data <= 1'b1;
            if (w_fault) begin
              d_ready <= 1'b1;
              d_fault <= 1'b1;
              d_rdata <= '0;
              r_state <= StResp;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= d_we;
              mem_addr  <= d_addr & ~LANE_MASK;
              mem_be    <= d_we ? w_st_be : '1;
              mem_wdata <= d_we ? w_st_data : '0;
              r_state   <= StData;
            end
          end else if (if_req) begin
            r_last_data <= 1'b0;
            r_word_sel  <= (DATA_WIDTH > 32) && (if_addr[2] ^ BIG_ENDIAN);
            mem_req     <= 1'b1;
            mem_we      <= 1'b0;
            mem_addr    <= if_addr & ~LANE_MASK;
            mem_be      <= '1;
            mem_wdata   <= '0;
            r_state     <= StFetch;
          end
        end
        StFetch: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= w_fetch_shifted[31:0];
            r_state  <= StResp;
          end
        end
        StData: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            d_ready <= 1'b1;
            d_fault <= 1'b0;
            d_rdata <= mem_we ? '0 : w_load;
            r_state <= StResp;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Parametrised successor to the CPU's single-port memory front end. It arbitrates an instruction-fetch port and a data load/store port onto one shared memory port, using a registered request/acknowledge handshake instead of clock-phase multiplexing. It performs byte/half/word/double lane alignment, byte-enable generation, load sign/zero extension and misalignment detection. It sits between the CPU core and the memory/bus.

## Interface
- DATA_WIDTH, 32, memory and data-port width; legal values are 32 or 64.
- ADDR_WIDTH, 32, byte address width.
- BIG_ENDIAN, 1, byte lane order; 1 = byte offset 0 sits in the most-significant lane (MIPS).
- clk  in  1  single clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  ADDR_WIDTH  fetch byte address; must be word-aligned (low 2 bits ignored).
- if_ready  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  32  fetched instruction word.
- d_req  in  1  data request; held with all d_* inputs until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_size  in  2  access size: 00 byte, 01 half, 10 word, 11 double (legal only when DATA_WIDTH=64).
- d_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0.
- d_addr  in  ADDR_WIDTH  data byte address.
- d_wdata  in  DATA_WIDTH  store data, right-justified.
- d_ready  out  1  one-cycle completion pulse.
- d_rdata  out  DATA_WIDTH  extended load result; 0 for stores and faults.
- d_fault  out  1  valid with d_ready: access was misaligned or used an illegal size.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  address with the lane bits forced to 0.
- mem_be  out  DATA_WIDTH/8  byte enables, all ones for reads.
- mem_wdata  out  DATA_WIDTH  lane-shifted store data.
- mem_ack  in  1  one-cycle completion; mem_rdata is valid in the same cycle.
- mem_rdata  in  DATA_WIDTH  raw read data.

## Operation
- FSM states: IDLE, FETCH, DATA, RESP.
  - IDLE samples requests.
  - FETCH and DATA hold mem_req until mem_ack.
  - RESP pulses the ready output for the granted port, then returns to IDLE.
- Arbitration happens in IDLE only.
  - One request pending: it is granted.
  - Both pending: round-robin; the port that was not granted last wins.
  - A last_grant flag resets to "fetch", so data wins the first tie.
- Fault check on a data grant:
  - Faulting conditions: half with addr[0]≠0; word with addr[1:0]≠0; double with addr[2:0]≠0; d_size=11 when DATA_WIDTH=32.
  - On fault, go IDLE→RESP directly: no mem_req, d_fault=1, d_rdata=0.
- Lane offset is k = addr[log2(DATA_WIDTH/8)-1:0].
  - BIG_ENDIAN=1: byte k occupies bits [DATA_WIDTH-1-8k -: 8].
  - BIG_ENDIAN=0: byte k occupies bits [8k +: 8].
- Stores: d_wdata is replicated or shifted into the addressed lanes. mem_be has 1, 2, 4 or 8 contiguous bits set, starting at lane k.
- Loads: the addressed lanes are extracted and sign- or zero-extended to DATA_WIDTH. The result is registered into d_rdata on mem_ack.
- Fetch with DATA_WIDTH=64: the 32-bit word is selected by addr[2] under the endian rule.
- mem_ack outside FETCH/DATA (for example, stale after reset) is ignored.
- Reset values:
  - Outputs: every output is 0.
  - State: FSM is IDLE and last_grant is "fetch".
- Reset mid-access: all outputs drop immediately and the in-flight transaction is abandoned. The requester must re-issue it.

## Timing
- mem_* outputs are registered.
  - Request sampled in IDLE at cycle 0: mem_req is high from cycle 1.
  - mem_ack at cycle n (n≥1): ready pulses at cycle n+1.
  - Minimum latency is 2 cycles from request to ready.
- Fault path: ready pulses at cycle 1.
- mem_addr, mem_we, mem_be and mem_wdata stay stable while mem_req is high.
- Ready outputs are high for exactly one cycle. A request still high during the RESP cycle is not re-granted. A new request is taken in the following IDLE cycle.
- Back-to-back throughput is one transaction per 3 cycles when mem_ack is immediate.

## Structure
- Shared package mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - the state enum;
  - a BYTES-per-word localparam helper.
- One sub-module, mem_load_align: combinational lane extraction plus sign/zero extension, parameterised by DATA_WIDTH and BIG_ENDIAN. Store alignment and be generation stay inline.

## Test plan
- Big-endian, 32-bit. lbu at addr 0x...01 with mem_rdata=0x11A23344 → d_rdata=0x000000A2. lb at the same address → 0xFFFFFFA2.
- sh at addr 0x...02 with d_wdata=0xBEEF → mem_be=0011, mem_wdata[15:0]=0xBEEF, mem_we=1. d_ready comes 1 cycle after mem_ack.
- lw at addr 0x...06 → d_ready at cycle 1, d_fault=1, mem_req never asserted. d_size=11 at DATA_WIDTH=32 → same response.
- if_req and d_req both held continuously with immediate ack → grants alternate data, fetch, data, fetch; each ready pulses every 6 cycles.
- Assert rst while mem_req=1 and before mem_ack → all outputs go 0 asynchronously. A mem_ack arriving after reset release produces no ready pulse.
- DATA_WIDTH=64, BIG_ENDIAN=0: ld at 0x...08 with mem_rdata=0x0123456789ABCDEF → d_rdata=0x0123456789ABCDEF. Fetch at 0x...04 → if_rdata=0x01234567.
